// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the ysyx_23060208 core: IFU FSM states, AXI
// response codes and the canonical nop encoding.
package ysyx_23060208_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060208_ifu.sv
// Instruction fetch unit: one AR/R read per pc update, result offered to decode
// on a valid/ready handshake. Define IFU_FAULT_CHECK_EN to add misalignment and
// bus-error detection with the inst_fault output.
module ysyx_23060208_ifu
  import ysyx_23060208_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_update,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  output logic                  rready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef IFU_FAULT_CHECK_EN
  ,
  output logic                  inst_fault
`endif
);

  ifu_state_e            state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  start;
`ifdef IFU_FAULT_CHECK_EN
  logic                  fault_q, fault_d;
`else
  logic                  rresp_unused;
  assign rresp_unused = ^rresp;
`endif

  // Every pc_update goes through pending: the fetch starts one edge later,
  // after the PC register has actually taken the new value.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    araddr_d     = araddr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    start        = 1'b0;
`ifdef IFU_FAULT_CHECK_EN
    fault_d      = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          start = 1'b1;
`ifdef IFU_FAULT_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            inst_d       = DATA_WIDTH'(NOP_INST);
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            fault_d      = 1'b1;
            state_d      = S_OUT;
          end else begin
            araddr_d = pc;
            state_d  = S_AR;
          end
`else
          araddr_d = pc;
          state_d  = S_AR;
`endif
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          inst_d       = rdata;
          inst_pc_d    = araddr_q;
          inst_valid_d = 1'b1;
          state_d      = S_OUT;
`ifdef IFU_FAULT_CHECK_EN
          fault_d = (rresp != RESP_OKAY);
          if (rresp != RESP_OKAY) inst_d = DATA_WIDTH'(NOP_INST);
`endif
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_IDLE;
`ifdef IFU_FAULT_CHECK_EN
          fault_d      = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start)     pending_d = 1'b0;
    if (pc_update) pending_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      araddr_q     <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
`ifdef IFU_FAULT_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
`ifdef IFU_FAULT_CHECK_EN
      fault_q      <= fault_d;
`endif
    end
  end

  assign arvalid    = (state_q == S_AR);
  assign rready     = (state_q == S_R);
  assign araddr     = araddr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
`ifdef IFU_FAULT_CHECK_EN
  assign inst_fault = fault_q;
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Directed bench for ysyx_23060208_ifu: boot fetch, backpressure, slow memory
// with a pending pc update, reset mid-read, and the optional fault checks.
module tb_ysyx_23060208_ifu;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_update;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_FAULT_CHECK_EN
  logic        inst_fault;
`endif

  int tests = 0;
  int fails = 0;
  int ar_hs = 0;
  int hs0;

  always #5 clock = ~clock;

  ysyx_23060208_ifu dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pc_update  (pc_update),
    .arvalid    (arvalid),
    .araddr     (araddr),
    .arready    (arready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rready     (rready),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
`ifdef IFU_FAULT_CHECK_EN
    ,
    .inst_fault (inst_fault)
`endif
  );

  always @(posedge clock) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pc = 32'h7FFF_FFFC; pc_update = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; inst_ready = 1'b0;
    repeat (5) tick();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_no_fetch", 32'(arvalid), 32'd0);

    // Boot fetch on a zero-wait memory
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0297;
    pc_update = 1'b1;
    tick();
    pc = 32'h8000_0000; pc_update = 1'b0;
    chk("boot_arvalid_early", 32'(arvalid), 32'd0);
    tick();
    chk("boot_arvalid", 32'(arvalid), 32'd1);
    chk("boot_araddr", araddr, 32'h8000_0000);
    tick();
    chk("boot_rready", 32'(rready), 32'd1);
    chk("boot_arvalid_drop", 32'(arvalid), 32'd0);
    tick();
    arready = 1'b0; rvalid = 1'b0;
    chk("boot_inst_valid", 32'(inst_valid), 32'd1);
    chk("boot_inst", inst, 32'h0000_0297);
    chk("boot_inst_pc", inst_pc, 32'h8000_0000);

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_inst_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'h0000_0297);
      chk("bp_inst_pc", inst_pc, 32'h8000_0000);
      chk("bp_arvalid", 32'(arvalid), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp_release", 32'(inst_valid), 32'd0);
    repeat (3) tick();
    chk("bp_no_refetch", 32'(arvalid), 32'd0);

    // Slow memory, plus a pc_update while the read is outstanding
    hs0 = ar_hs;
    pc_update = 1'b1;
    tick();
    pc = 32'h8000_0004; pc_update = 1'b0;
    tick();
    chk("slow_arvalid", 32'(arvalid), 32'd1);
    chk("slow_araddr", araddr, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("slow_ar_hold_valid", 32'(arvalid), 32'd1);
      chk("slow_ar_hold_addr", araddr, 32'h8000_0004);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("slow_rready", 32'(rready), 32'd1);
    pc_update = 1'b1;
    tick();
    pc = 32'h8000_0008; pc_update = 1'b0;
    repeat (4) tick();
    chk("slow_wait_valid", 32'(inst_valid), 32'd0);
    chk("slow_wait_arvalid", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rdata = 32'h0010_0093;
    tick();
    rvalid = 1'b0;
    chk("slow_inst_valid", 32'(inst_valid), 32'd1);
    chk("slow_inst", inst, 32'h0010_0093);
    chk("slow_inst_pc", inst_pc, 32'h8000_0004);
    chk("slow_one_ar_hs", 32'(ar_hs - hs0), 32'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("pend_hs_valid", 32'(inst_valid), 32'd0);
    chk("pend_idle_arvalid", 32'(arvalid), 32'd0);
    tick();
    chk("pend_arvalid", 32'(arvalid), 32'd1);
    chk("pend_araddr", araddr, 32'h8000_0008);

    // Reset while waiting for read data
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rst_sr_rready", 32'(rready), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_sr_arvalid", 32'(arvalid), 32'd0);
    chk("rst_sr_rready_lo", 32'(rready), 32'd0);
    chk("rst_sr_inst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    repeat (2) tick();
    rvalid = 1'b0;
    chk("late_r_valid", 32'(inst_valid), 32'd0);
    chk("late_r_arvalid", 32'(arvalid), 32'd0);

`ifdef IFU_FAULT_CHECK_EN
    pc_update = 1'b1;
    tick();
    pc = 32'h8000_0002; pc_update = 1'b0;
    tick();
    chk("mis_arvalid", 32'(arvalid), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_fault", 32'(inst_fault), 32'd1);
    chk("mis_inst", inst, 32'h0000_0013);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("mis_clear", 32'(inst_fault), 32'd0);
    pc_update = 1'b1;
    tick();
    pc = 32'h8000_000C; pc_update = 1'b0;
    tick();
    chk("err_arvalid", 32'(arvalid), 32'd1);
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h1234_5678;
    repeat (2) tick();
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    chk("err_valid", 32'(inst_valid), 32'd1);
    chk("err_fault", 32'(inst_fault), 32'd1);
    chk("err_inst", inst, 32'h0000_0013);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
